image_frame_reader: RTL and testbench
=====================================

// Module: image_frame_reader
// PURPOSE
//  Raster-scan read engine feeding the shared image bank. On start, latches one image select, walks
//  bank addresses 0..IMG_W*IMG_H-1 and streams 24-bit RGB pixels to the downstream filter/display
//  path over a valid/ready interface. Absorbs the bank's 1-cycle read latency and downstream
//  backpressure with a 2-entry skid FIFO. Provides sof/eol/eof framing.
// PARAMETERS
//  IMG_W   320  pixels per line
//  IMG_H   240  lines per frame; IMG_W*IMG_H must be <= 2**ADDR_W
//  ADDR_W  17   bank address width
//  PIX_W   24   pixel width, RGB888
// PORTS
//  clock     in   1       system clock; all logic on rising edge
//  reset     in   1       asynchronous, active-high reset
//  start     in   1       1-cycle pulse; begins a frame when idle
//  sel_in    in   3       one-hot image select, sampled only on accepted start
//  busy      out  1       high from accepted start until last pixel handshaken
//  done      out  1       1-cycle pulse on cycle after last pixel handshake
//  rom_addr  out  ADDR_W  bank address
//  rom_sel   out  3       latched one-hot select to bank; held constant for whole frame
//  rom_q     in   PIX_W   bank data, valid 1 cycle after rom_addr
//  m_data    out  PIX_W   pixel out
//  m_valid   out  1       m_data valid
//  m_ready   in   1       downstream accepts when m_valid & m_ready
//  m_sof     out  1       qualifies first pixel of frame (x=0,y=0)
//  m_eol     out  1       qualifies last pixel of each line (x=IMG_W-1)
//  m_eof     out  1       qualifies last pixel of frame
// BEHAVIOUR
//  Reset values: busy=0, done=0, rom_addr=0, rom_sel=3'b001, m_valid=0, m_data=0, flags=0; FIFO empty.
//  FSM: IDLE -> (start) RUN -> (last address issued) DRAIN -> (FIFO empty, in-flight=0) IDLE.
//   IDLE: start accepted -> latch sel_in into rom_sel; non-one-hot sel_in (incl 000) -> 3'b001.
//   start while busy is ignored; sel_in changes mid-frame have no effect.
//  Issue rule (RUN): read issued in cycle t iff (fifo_count + inflight - pop_t) < 2; on issue
//   rom_addr increments next cycle; rom_q captured into FIFO at t+1 with its x/y tags.
//   Never overflows; never drops or duplicates a pixel under any m_ready pattern.
//  Throughput: with m_ready held high, one pixel per cycle; first m_valid 2 cycles after start
//   (start cycle latch, addr 0 issue, data captured); frame takes IMG_W*IMG_H+2 cycles to done.
//  Output: m_valid = FIFO non-empty; m_data/flags stable while m_valid & !m_ready.
//  Counters: x wraps IMG_W-1 -> 0 with y+1; address = y*IMG_W+x maintained incrementally
//   (no multiplier); last address IMG_W*IMG_H-1; no wrap past it.
//  done asserts exactly once per frame, same cycle busy falls; start in that cycle is accepted
//   (back-to-back frames) and re-latches sel_in.
//  Reset mid-frame: everything returns to reset values immediately; no partial-frame completion.
// STRUCTURE
//  Shared package img_pkg: IMG_W, IMG_H, ADDR_W, PIX_W, SEL_IMG0/1/2 one-hot constants,
//   FSM state encoding (IDLE/RUN/DRAIN).
//  One sub-module: pix_skid_fifo (2-entry, PIX_W+3 wide: data+sof/eol/eof, count output).
//  Top holds FSM, x/y/address counters, in-flight flag, select latch.
// TESTING
//  1 m_ready=1, sel_in=3'b010, start -> 76800 pixels in 76800 consecutive cycles, first at cycle 2,
//    data matches image_02 model, sof on #0, eol on every x=319, eof on #76799, done once.
//  2 m_ready random 30% duty -> identical pixel sequence to test 1, no drop/dup, data stable
//    while stalled, rom_addr never more than 2 ahead of last accepted pixel.
//  3 sel_in=3'b101 at start -> rom_sel=3'b001; toggling sel_in mid-frame -> rom_sel unchanged.
//  4 start pulses at pixel 1000 -> ignored; start on done cycle with sel_in=3'b100 -> second frame
//    begins with no gap, rom_sel=3'b100.
//  5 reset asserted at pixel 40000 with m_ready=0 -> next cycle m_valid=0, busy=0,
//    rom_addr=0; following start produces full frame from address 0.
//  6 m_ready=0 held 1000 cycles after start -> m_valid=1 with pixel 0, exactly 2 reads issued.

Source files
------------

// File: rtl/img_pkg.sv
// Shared constants, select encodings and FSM states for the raster-scan frame reader.
package img_pkg;

   localparam int IMG_W  = 320;
   localparam int IMG_H  = 240;
   localparam int ADDR_W = 17;
   localparam int PIX_W  = 24;

   localparam logic [2:0] SEL_IMG0 = 3'b001;
   localparam logic [2:0] SEL_IMG1 = 3'b010;
   localparam logic [2:0] SEL_IMG2 = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Anything that is not a legal one-hot image select falls back to image 0.
   function automatic logic [2:0] sanitize_sel(input logic [2:0] sel);
      case (sel)
         SEL_IMG0, SEL_IMG1, SEL_IMG2: return sel;
         default:                      return SEL_IMG0;
      endcase
   endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry skid FIFO carrying a pixel plus its sof/eol/eof tags.
// The caller guarantees no push when full and no pop when empty.
module pix_skid_fifo #(
   parameter int W = 27
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/image_frame_reader.sv
// Raster-scan reader: walks bank addresses for one latched image and streams RGB pixels
// over valid/ready with sof/eol/eof framing, hiding the bank's 1-cycle read latency.
module image_frame_reader #(
   parameter int IMG_W  = img_pkg::IMG_W,
   parameter int IMG_H  = img_pkg::IMG_H,
   parameter int ADDR_W = img_pkg::ADDR_W,
   parameter int PIX_W  = img_pkg::PIX_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        sel_in,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [2:0]        rom_sel,
   input  logic [PIX_W-1:0]  rom_q,
   output logic [PIX_W-1:0]  m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_eof,
   output img_pkg::state_t   dbg_state
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   img_pkg::state_t state, state_nx;
   logic            done_nx;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic            inflight;
   logic            tag_sof, tag_eol, tag_eof;
   logic [1:0]      fifo_count;
   logic [PIX_W+2:0] head;
   logic            pop;
   logic            issue;
   logic            last_pos;
   logic [2:0]      occupancy;

   // Handshake: a pixel transfers on a rising edge where m_valid and m_ready are both high;
   // m_data and flags hold while m_valid is high and m_ready is low.
   assign m_valid   = (fifo_count != 2'd0);
   assign pop       = m_valid & m_ready;
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
   assign issue     = (state == img_pkg::RUN) && (occupancy < 3'd2);
   assign last_pos  = (x == X_LAST) && (y == Y_LAST);

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      case (state)
         img_pkg::IDLE:  if (start) state_nx = img_pkg::RUN;
         img_pkg::RUN:   if (issue && last_pos) state_nx = img_pkg::DRAIN;
         img_pkg::DRAIN: begin
            if (pop && head[PIX_W]) begin
               state_nx = img_pkg::IDLE;
               done_nx  = 1'b1;
            end
         end
         default:        state_nx = img_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= img_pkg::IDLE;
         done     <= 1'b0;
         rom_sel  <= img_pkg::SEL_IMG0;
         rom_addr <= '0;
         x        <= '0;
         y        <= '0;
         inflight <= 1'b0;
         tag_sof  <= 1'b0;
         tag_eol  <= 1'b0;
         tag_eof  <= 1'b0;
      end else begin
         state    <= state_nx;
         done     <= done_nx;
         inflight <= issue;
         if (state == img_pkg::IDLE && start) begin
            rom_sel <= img_pkg::sanitize_sel(sel_in);
         end
         // Tags travel alongside the read so they line up with rom_q one cycle later.
         if (issue) begin
            tag_sof <= (rom_addr == '0);
            tag_eol <= (x == X_LAST);
            tag_eof <= last_pos;
         end
         if (done_nx) begin
            rom_addr <= '0;
            x        <= '0;
            y        <= '0;
         end else if (issue && !last_pos) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            if (x == X_LAST) begin
               x <= '0;
               y <= y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

   pix_skid_fifo #(.W(PIX_W + 3)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (inflight),
      .push_data ({tag_sof, tag_eol, tag_eof, rom_q}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   assign m_data    = head[PIX_W-1:0];
   assign m_eof     = m_valid & head[PIX_W];
   assign m_eol     = m_valid & head[PIX_W+1];
   assign m_sof     = m_valid & head[PIX_W+2];
   assign busy      = (state != img_pkg::IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_image_frame_reader.sv
// Scoreboard bench for image_frame_reader on a small 8x4 image: expected pixels are queued
// at each start, and a negedge monitor pops and compares on every handshake.
module tb_image_frame_reader;

   localparam int IMG_W  = 8;
   localparam int IMG_H  = 4;
   localparam int ADDR_W = 5;
   localparam int PIX_W  = 24;
   localparam int N      = IMG_W * IMG_H;

   logic              clock;
   logic              reset;
   logic              start;
   logic [2:0]        sel_in;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_addr;
   logic [2:0]        rom_sel;
   logic [PIX_W-1:0]  rom_q;
   logic [PIX_W-1:0]  m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_sof, m_eol, m_eof;
   img_pkg::state_t   dbg_state;

   logic [PIX_W+2:0]  exp_q[$];
   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int done_cnt = 0;
   int acc_in_frame = 0;
   logic rand_ready = 1'b0;
   logic chk_ahead  = 1'b0;
   logic prev_stall = 1'b0;
   logic [PIX_W+2:0] prev_word = '0;

   image_frame_reader #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .sel_in(sel_in),
      .busy(busy), .done(done), .rom_addr(rom_addr), .rom_sel(rom_sel),
      .rom_q(rom_q), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- image bank model ----------------
   function automatic logic [PIX_W-1:0] img(input logic [2:0] sel, input int idx);
      return {sel, 5'h0A, 8'(idx * 7), 8'(idx)};
   endfunction

   always @(posedge clock) rom_q <= img(rom_sel, int'(rom_addr));

   always @(posedge clock) begin
      #1;
      if (rand_ready) m_ready = ($urandom_range(0, 9) < 3);
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      logic [PIX_W+2:0] got;
      logic [PIX_W+2:0] e;
      if (reset) begin
         prev_stall   = 1'b0;
         acc_in_frame = 0;
      end else begin
         got = {m_sof, m_eol, m_eof, m_data};
         if (done) done_cnt++;
         if (prev_stall) check("stall_hold", {m_valid, got}, {1'b1, prev_word});
         if (chk_ahead && busy) check("addr_ahead", 64'(int'(rom_addr) <= acc_in_frame + 2), 64'd1);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("pixel_unexpected", 64'(got), 64'h0);
            end else begin
               e = exp_q.pop_front();
               check("pixel", 64'(got), 64'(e));
            end
            if (m_eof) acc_in_frame = 0;
            else       acc_in_frame++;
         end
         prev_stall = m_valid && !m_ready;
         prev_word  = got;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_frame(input logic [2:0] sel);
      for (int i = 0; i < N; i++)
         exp_q.push_back({(i == 0), ((i % IMG_W) == IMG_W - 1), (i == N - 1), img(sel, i)});
   endtask

   // Called at a negedge; raises start for one cycle and returns c0 = cycle count after the start edge.
   task automatic launch(input logic [2:0] drive_sel, input logic [2:0] exp_sel, output int c0);
      start  = 1'b1;
      sel_in = drive_sel;
      push_frame(exp_sel);
      @(negedge clock);
      start = 1'b0;
      c0    = cyc;
   endtask

   task automatic wait_valid(input int c0);
      bit found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clock);
         if (m_valid) begin
            found = 1'b1;
            check("first_valid_latency", 64'(cyc - c0), 64'd2);
         end
      end
      if (!found) check("first_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_done(output int dc);
      bit found = 1'b0;
      dc = -1;
      for (int k = 0; k < 40 * N + 200 && !found; k++) begin
         @(negedge clock);
         if (done) begin
            found = 1'b1;
            dc    = cyc;
         end
      end
      if (!found) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_acc(input int n);
      bit found = 1'b0;
      for (int k = 0; k < 40 * N && !found; k++) begin
         @(negedge clock);
         if (acc_in_frame >= n) found = 1'b1;
      end
      if (!found) check("acc_timeout", 64'd0, 64'd1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int c0, dc;
      logic [2:0] toggles [5];
      toggles = '{3'b010, 3'b100, 3'b011, 3'b000, 3'b111};
      reset = 1'b1; start = 1'b0; sel_in = 3'b000; m_ready = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_busy",    64'(busy),     64'd0);
      check("rst_done",    64'(done),     64'd0);
      check("rst_addr",    64'(rom_addr), 64'd0);
      check("rst_sel",     64'(rom_sel),  64'h1);
      check("rst_valid",   64'(m_valid),  64'd0);
      check("rst_data",    64'(m_data),   64'd0);
      check("rst_flags",   64'({m_sof, m_eol, m_eof}), 64'd0);
      check("rst_state",   64'(dbg_state), 64'(img_pkg::IDLE));
      @(posedge clock); #2 reset = 1'b0;

      // 1: continuous ready, image 010
      @(negedge clock);
      launch(3'b010, 3'b010, c0);
      wait_valid(c0);
      check("t1_pix0_data", 64'(m_data), 64'h4A0000);
      check("t1_pix0_sof",  64'(m_sof),  64'd1);
      wait_done(dc);
      check("t1_frame_cycles", 64'(dc - c0), 64'(N + 2));
      check("t1_busy_at_done", 64'(busy), 64'd0);
      @(negedge clock);
      check("t1_done_width", 64'(done), 64'd0);
      check("t1_done_count", 64'(done_cnt), 64'd1);

      // 2: random 30% ready, same image
      @(posedge clock); #1 rand_ready = 1'b1;
      chk_ahead = 1'b1;
      @(negedge clock);
      launch(3'b010, 3'b010, c0);
      wait_done(dc);
      chk_ahead  = 1'b0;
      rand_ready = 1'b0;
      @(posedge clock); #1 m_ready = 1'b1;

      // 3: illegal select falls back to image 0, mid-frame select changes ignored
      @(negedge clock);
      launch(3'b101, 3'b001, c0);
      check("t3_sel_fallback", 64'(rom_sel), 64'h1);
      wait_valid(c0);
      check("t3_pix0_data", 64'(m_data), 64'h2A0000);
      for (int i = 0; i < 5; i++) begin
         sel_in = toggles[i];
         repeat (3) @(negedge clock);
         check("t3_sel_hold", 64'(rom_sel), 64'h1);
      end
      wait_done(dc);

      // 4: start mid-frame ignored; start on done cycle begins next frame back-to-back
      @(negedge clock);
      launch(3'b001, 3'b001, c0);
      wait_acc(10);
      start = 1'b1; sel_in = 3'b010;
      @(negedge clock);
      start = 1'b0;
      check("t4_mid_start_busy", 64'(busy), 64'd1);
      check("t4_mid_start_sel",  64'(rom_sel), 64'h1);
      wait_done(dc);
      launch(3'b100, 3'b100, c0);
      check("t4_b2b_busy", 64'(busy), 64'd1);
      check("t4_b2b_sel",  64'(rom_sel), 64'h4);
      wait_valid(c0);
      check("t4_b2b_pix0", 64'(m_data), 64'h8A0000);
      wait_done(dc);
      check("t4_b2b_frame_cycles", 64'(dc - c0), 64'(N + 2));

      // 5: reset mid-frame while stalled, then a clean full frame
      @(negedge clock);
      launch(3'b010, 3'b010, c0);
      wait_acc(20);
      @(posedge clock); #1 m_ready = 1'b0;
      @(posedge clock); #2 reset = 1'b1;
      exp_q.delete();
      @(negedge clock);
      check("t5_valid", 64'(m_valid),  64'd0);
      check("t5_busy",  64'(busy),     64'd0);
      check("t5_addr",  64'(rom_addr), 64'd0);
      check("t5_sel",   64'(rom_sel),  64'h1);
      check("t5_done",  64'(done),     64'd0);
      @(posedge clock); #2 reset = 1'b0; m_ready = 1'b1;
      @(negedge clock);
      launch(3'b010, 3'b010, c0);
      wait_valid(c0);
      wait_done(dc);
      check("t5_frame_cycles", 64'(dc - c0), 64'(N + 2));

      // 6: ready held low after start: pixel 0 presented, only two reads issued
      @(posedge clock); #1 m_ready = 1'b0;
      @(negedge clock);
      launch(3'b010, 3'b010, c0);
      repeat (50) @(negedge clock);
      check("t6_valid", 64'(m_valid),  64'd1);
      check("t6_data",  64'(m_data),   64'h4A0000);
      check("t6_sof",   64'(m_sof),    64'd1);
      check("t6_reads", 64'(rom_addr), 64'd2);
      @(posedge clock); #1 m_ready = 1'b1;
      wait_done(dc);

      repeat (5) @(negedge clock);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("done_total",  64'(done_cnt),     64'd7);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
